// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the parametrised UART receiver.
//   - parity-mode encodings (PAR_RSVD is received as "no parity")
//   - receiver FSM state enum
//   - eight-entry baud-rate table indexed by baud_select
//   - baud_div(): rounded 16x-oversampling divisor for a clock and rate
//   - maj3(): 2-of-3 majority vote
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;
    localparam logic [1:0] PAR_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_STOP2  = 3'd5,
        ST_DONE   = 3'd6
    } uart_state_e;

    localparam int unsigned BAUD_TABLE [8] = '{
        300, 1200, 4800, 9600, 19200, 38400, 57600, 115200
    };

    // round(clk_hz / (16 * baud)) in integer arithmetic.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input logic [2:0]  sel);
        int unsigned baud;
        baud = BAUD_TABLE[sel];
        return (clk_hz + 8 * baud) / (16 * baud);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16x oversampling tick generator.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   baud_select    - index into the baud-rate table
//   restart        - zero the divider so the next tick lands a full
//                    divisor period later (aligns phase to a start edge)
//   sample_enable  - one-clock pulse every divisor clocks
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] baud_select,
    input  logic       restart,
    output logic       sample_enable
);

    // Divisors are folded to constants at elaboration; the slowest rate
    // (table entry 0) sets the counter width.
    localparam int unsigned DIV_TAB [8] = '{
        baud_div(CLK_HZ, 3'd0), baud_div(CLK_HZ, 3'd1),
        baud_div(CLK_HZ, 3'd2), baud_div(CLK_HZ, 3'd3),
        baud_div(CLK_HZ, 3'd4), baud_div(CLK_HZ, 3'd5),
        baud_div(CLK_HZ, 3'd6), baud_div(CLK_HZ, 3'd7)
    };
    localparam int CNT_W = $clog2(DIV_TAB[0]);

    logic [CNT_W-1:0] cnt_q, cnt_d, div_m1;

    assign div_m1        = CNT_W'(DIV_TAB[baud_select] - 1);
    assign sample_enable = (cnt_q == div_m1) && !restart;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || sample_enable) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver, 16x oversampling, 2-of-3 vote.
// Ports:
//   clk, reset_n              - clock, asynchronous active-low reset
//   baud_select, parity_mode,
//   two_stop                  - frame config, captured at the start edge
//   Rx_EN                     - enable; low forces the FSM to IDLE
//   Rx_D                      - asynchronous serial line (idle high)
//   Rx_DATA, Rx_PERROR,
//   Rx_FERROR, Rx_BREAK       - presented word and its flags
//   Rx_VALID / Rx_READY       - handshake: the word transfers on any cycle
//                               where both are high; Rx_VALID holds the word
//                               stable until then. A word completed while
//                               the previous one is still pending (and not
//                               being accepted in that same cycle) is dropped
//                               and Rx_OVERRUN pulses for one clock.
//   dbg_state                 - current FSM state, for observation
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           baud_select,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 Rx_EN,
    input  logic                 Rx_D,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    input  logic                 Rx_READY,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR,
    output logic                 Rx_BREAK,
    output logic                 Rx_OVERRUN,
    output uart_state_e          dbg_state
);

    localparam int IDX_W = $clog2(DATA_BITS);

    logic                 meta_q, sync_q;
    logic [1:0]           samp_q;        // previous synced samples, newest in [0]
    uart_state_e          state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [1:0]           vote_q, vote_d; // samples taken at ticks 7 and 8
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop1_q, stop1_d, stop2_q, stop2_d;
    logic [2:0]           baud_q, baud_d;
    logic [1:0]           par_q, par_d;
    logic                 two_stop_q, two_stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                 brk_q, brk_d, ovr_q, ovr_d;

    logic tick, start_edge, bit_val, start_vote, par_en, load;
    logic frame_perr, frame_ferr, frame_brk;

    assign start_edge = Rx_EN && (state_q == ST_IDLE) && samp_q[0] && !sync_q;
    // The tick-9 sample completes the vote, so use the live line for it.
    assign bit_val    = maj3(vote_q[1], vote_q[0], sync_q);
    // The start bit is judged at tick 7 over the three most recent samples.
    assign start_vote = maj3(samp_q[1], samp_q[0], sync_q);

    uart_baud_tick #(.CLK_HZ(CLK_HZ)) u_baud (
        .clk          (clk),
        .reset_n      (reset_n),
        .baud_select  (baud_q),
        .restart      (start_edge || !Rx_EN),
        .sample_enable(tick)
    );

    assign par_en     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign frame_perr = par_en && (((^shift_q) ^ par_bit_q) != (par_q == PAR_ODD));
    assign frame_ferr = !stop1_q || (two_stop_q && !stop2_q);
    assign frame_brk  = (shift_q == '0) && !(par_en && par_bit_q) && !stop1_q;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_idx_d  = bit_idx_q;
        vote_d     = vote_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        stop1_d    = stop1_q;
        stop2_d    = stop2_q;
        baud_d     = baud_q;
        par_d      = par_q;
        two_stop_d = two_stop_q;

        if (tick) begin
            tick_d = tick_q + 4'd1;
            if (tick_q == 4'd7 || tick_q == 4'd8) begin
                vote_d = {vote_q[0], sync_q};
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d    = ST_START;
                    tick_d     = '0;
                    bit_idx_d  = '0;
                    baud_d     = baud_select;
                    par_d      = parity_mode;
                    two_stop_d = two_stop;
                end
            end
            ST_START: begin
                if (tick && tick_q == 4'd7 && start_vote) begin
                    state_d = ST_IDLE;
                end else if (tick && tick_q == 4'd15) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick && tick_q == 4'd9) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                end else if (tick && tick_q == 4'd15) begin
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick && tick_q == 4'd9) begin
                    par_bit_d = bit_val;
                end else if (tick && tick_q == 4'd15) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Completing at tick 9 leaves slack to catch the next start edge.
                if (tick && tick_q == 4'd9) begin
                    stop1_d = bit_val;
                    if (!two_stop_q) begin
                        state_d = ST_DONE;
                    end
                end else if (tick && tick_q == 4'd15) begin
                    state_d = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (tick && tick_q == 4'd9) begin
                    stop2_d = bit_val;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (!Rx_EN) begin
            state_d   = ST_IDLE;
            tick_d    = '0;
            bit_idx_d = '0;
        end
    end

    // Output register: a new word may replace the pending one only in the
    // cycle the pending one is accepted.
    always_comb begin
        load    = (state_q == ST_DONE) && (!valid_q || Rx_READY);
        valid_d = valid_q && !Rx_READY;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;
        ovr_d   = 1'b0;
        if (load) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            perr_d  = frame_perr;
            ferr_d  = frame_ferr;
            brk_d   = frame_brk;
        end else if (state_q == ST_DONE) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q     <= 1'b1;
            sync_q     <= 1'b1;
            samp_q     <= 2'b11;
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            bit_idx_q  <= '0;
            vote_q     <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            stop1_q    <= 1'b1;
            stop2_q    <= 1'b1;
            baud_q     <= '0;
            par_q      <= PAR_NONE;
            two_stop_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            meta_q     <= Rx_D;
            sync_q     <= meta_q;
            samp_q     <= {samp_q[0], sync_q};
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_idx_q  <= bit_idx_d;
            vote_q     <= vote_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            stop1_q    <= stop1_d;
            stop2_q    <= stop2_d;
            baud_q     <= baud_d;
            par_q      <= par_d;
            two_stop_q <= two_stop_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
        end
    end

    assign Rx_DATA    = data_q;
    assign Rx_VALID   = valid_q;
    assign Rx_PERROR  = perr_q;
    assign Rx_FERROR  = ferr_q;
    assign Rx_BREAK   = brk_q;
    assign Rx_OVERRUN = ovr_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8-bit and a 7-bit instance share
// clock, reset, config and Rx_READY; each has its own serial line.
// Inputs change 2 ns after a rising edge; monitors sample on falling edges.
module tb_uart_rx_param;
    import uart_pkg::*;

    // 50 MHz: 115200 -> divisor 27 (27.13), 9600 -> divisor 326 (325.52)
    localparam int BIT_115  = 16 * 27;
    localparam int TICK_9600 = 326;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  baud_select = 3'd7;
    logic [1:0]  parity_mode = PAR_NONE;
    logic        two_stop = 1'b0;
    logic        rx_en = 1'b1;
    logic        rx_ready = 1'b1;
    logic        rx_d8 = 1'b1;
    logic        rx_d7 = 1'b1;

    logic [7:0]  data8;
    logic        valid8, perr8, ferr8, brk8, ovr8;
    uart_state_e st8;
    logic [6:0]  data7;
    logic        valid7, perr7, ferr7, brk7, ovr7;
    uart_state_e st7;

    int n_checks = 0;
    int n_err = 0;
    // Expected words: {break, ferror, perror, data[8:0]}
    logic [11:0] exp8_q[$];
    logic [11:0] exp7_q[$];
    int   loads8 = 0, loads7 = 0, ovr_cnt8 = 0, ovr_cnt7 = 0;
    int   run8 = 0, last_run8 = 0;
    int   ovr_base, loads_base;
    logic v8_prev = 1'b0, acc8_prev = 1'b0, v7_prev = 1'b0, acc7_prev = 1'b0;
    bit   done_seen;

    always #10 clk = ~clk;

    uart_rx_param #(.CLK_HZ(50_000_000), .DATA_BITS(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .baud_select(baud_select),
        .parity_mode(parity_mode), .two_stop(two_stop), .Rx_EN(rx_en),
        .Rx_D(rx_d8), .Rx_DATA(data8), .Rx_VALID(valid8), .Rx_READY(rx_ready),
        .Rx_PERROR(perr8), .Rx_FERROR(ferr8), .Rx_BREAK(brk8),
        .Rx_OVERRUN(ovr8), .dbg_state(st8)
    );

    uart_rx_param #(.CLK_HZ(50_000_000), .DATA_BITS(7)) dut7 (
        .clk(clk), .reset_n(reset_n), .baud_select(baud_select),
        .parity_mode(parity_mode), .two_stop(two_stop), .Rx_EN(rx_en),
        .Rx_D(rx_d7), .Rx_DATA(data7), .Rx_VALID(valid7), .Rx_READY(rx_ready),
        .Rx_PERROR(perr7), .Rx_FERROR(ferr7), .Rx_BREAK(brk7),
        .Rx_OVERRUN(ovr7), .dbg_state(st7)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: a load is a rising Rx_VALID, or Rx_VALID still high right
    // after a cycle in which the previous word was accepted.
    always @(negedge clk) begin
        if (valid8 && (!v8_prev || acc8_prev)) begin
            loads8++;
            check("load8_expected", 32'(exp8_q.size() != 0), 32'd1);
            if (exp8_q.size() != 0)
                check("word8", {20'd0, brk8, ferr8, perr8, 1'b0, data8}, {20'd0, exp8_q.pop_front()});
        end
        if (ovr8) ovr_cnt8++;
        if (valid8) run8++;
        else begin
            if (run8 != 0) last_run8 = run8;
            run8 = 0;
        end
        v8_prev   = valid8;
        acc8_prev = valid8 && rx_ready;
    end

    always @(negedge clk) begin
        if (valid7 && (!v7_prev || acc7_prev)) begin
            loads7++;
            check("load7_expected", 32'(exp7_q.size() != 0), 32'd1);
            if (exp7_q.size() != 0)
                check("word7", {20'd0, brk7, ferr7, perr7, 2'b00, data7}, {20'd0, exp7_q.pop_front()});
        end
        if (ovr7) ovr_cnt7++;
        v7_prev   = valid7;
        acc7_prev = valid7 && rx_ready;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit to7, input logic v, input int n);
        if (to7) rx_d7 = v;
        else     rx_d8 = v;
        wait_clks(n);
    endtask

    task automatic send_frame(input bit to7, input int nbits, input logic [8:0] data,
                              input bit use_par, input logic par_bit,
                              input int nstop, input logic stop_val);
        drive(to7, 1'b0, BIT_115);
        for (int i = 0; i < nbits; i++) drive(to7, data[i], BIT_115);
        if (use_par) drive(to7, par_bit, BIT_115);
        for (int i = 0; i < nstop; i++) drive(to7, stop_val, BIT_115);
        if (to7) rx_d7 = 1'b1;
        else     rx_d8 = 1'b1;
    endtask

    initial begin
        // Reset state
        wait_clks(5);
        check("rst_data8",  32'(data8),  32'd0);
        check("rst_valid8", 32'(valid8), 32'd0);
        check("rst_flags8", {29'd0, perr8, ferr8, brk8}, 32'd0);
        check("rst_ovr8",   32'(ovr8),   32'd0);
        check("rst_state8", 32'(st8),    32'(ST_IDLE));
        check("rst_valid7", 32'(valid7), 32'd0);
        reset_n = 1'b1;
        wait_clks(10);

        // 8N1, 115200, 0xA5, ready held high
        exp8_q.push_back({3'b000, 9'h0A5});
        send_frame(1'b0, 8, 9'h0A5, 1'b0, 1'b0, 1, 1'b1);
        wait_clks(40);
        check("a5_loads",     32'(loads8),    32'd1);
        check("a5_valid_len", 32'(last_run8), 32'd1);
        check("a5_no_ovr",    32'(ovr_cnt8),  32'd0);

        // 7 data bits, odd parity, two stops: 0x35 has four ones -> parity bit 1
        parity_mode = PAR_ODD;
        two_stop    = 1'b1;
        exp7_q.push_back({3'b000, 9'h035});
        exp7_q.push_back({3'b001, 9'h035});
        send_frame(1'b1, 7, 9'h035, 1'b1, 1'b1, 2, 1'b1);
        wait_clks(40);
        send_frame(1'b1, 7, 9'h035, 1'b1, 1'b0, 2, 1'b1);
        wait_clks(40);
        check("par7_loads", 32'(loads7), 32'd2);

        // 4-clock glitch at 9600: START entered, rejected before tick 8
        parity_mode = PAR_NONE;
        two_stop    = 1'b0;
        baud_select = 3'd3;
        rx_d8 = 1'b0;
        wait_clks(4);
        rx_d8 = 1'b1;
        wait_clks(100);
        check("glitch_in_start", 32'(st8), 32'(ST_START));
        wait_clks(7 * TICK_9600 + 384);   // ~c0+2770: after tick 7, before tick 8
        check("glitch_idle", 32'(st8), 32'(ST_IDLE));
        wait_clks(200);
        check("glitch_no_load", 32'(loads8), 32'd1);
        check("glitch_valid",   32'(valid8), 32'd0);
        baud_select = 3'd7;
        wait_clks(10);

        // Framing error, then break
        exp8_q.push_back({3'b010, 9'h03C});
        send_frame(1'b0, 8, 9'h03C, 1'b0, 1'b0, 1, 1'b0);
        wait_clks(40);
        exp8_q.push_back({3'b110, 9'h000});
        send_frame(1'b0, 8, 9'h000, 1'b0, 1'b0, 1, 1'b0);
        wait_clks(40);
        check("ferr_brk_loads", 32'(loads8), 32'd3);

        // Overrun: ready low, 0x11 then 0x22 back to back
        rx_ready = 1'b0;
        ovr_base = ovr_cnt8;
        exp8_q.push_back({3'b000, 9'h011});
        send_frame(1'b0, 8, 9'h011, 1'b0, 1'b0, 1, 1'b1);
        send_frame(1'b0, 8, 9'h022, 1'b0, 1'b0, 1, 1'b1);
        wait_clks(40);
        check("ovr_data_held", 32'(data8), 32'h11);
        check("ovr_valid_held", 32'(valid8), 32'd1);
        check("ovr_pulses", 32'(ovr_cnt8 - ovr_base), 32'd1);
        check("ovr_loads", 32'(loads8), 32'd4);

        // Ready raised in the DONE cycle of 0x22: loads, no overrun
        ovr_base  = ovr_cnt8;
        done_seen = 1'b0;
        exp8_q.push_back({3'b000, 9'h022});
        fork
            send_frame(1'b0, 8, 9'h022, 1'b0, 1'b0, 1, 1'b1);
            begin
                for (int i = 0; i < 6000 && !done_seen; i++) begin
                    wait_clks(1);
                    if (st8 == ST_DONE) begin
                        rx_ready  = 1'b1;
                        done_seen = 1'b1;
                    end
                end
            end
        join
        check("done_seen", 32'(done_seen), 32'd1);
        wait_clks(40);
        check("ready_done_no_ovr", 32'(ovr_cnt8 - ovr_base), 32'd0);
        check("ready_done_loads", 32'(loads8), 32'd5);
        check("ready_done_data", 32'(data8), 32'h22);
        check("ready_done_drained", 32'(valid8), 32'd0);

        // Reset in the middle of data bit 4, then a clean 0x5A
        loads_base = loads8;
        drive(1'b0, 1'b0, BIT_115);
        drive(1'b0, 1'b1, BIT_115);
        drive(1'b0, 1'b0, BIT_115);
        drive(1'b0, 1'b1, BIT_115);
        drive(1'b0, 1'b0, BIT_115);
        drive(1'b0, 1'b1, BIT_115 / 2);
        reset_n = 1'b0;
        wait_clks(3);
        check("midrst_data8",  32'(data8),  32'd0);
        check("midrst_valid8", 32'(valid8), 32'd0);
        check("midrst_state8", 32'(st8),    32'(ST_IDLE));
        reset_n = 1'b1;
        wait_clks(BIT_115);
        check("midrst_no_load", 32'(loads8 - loads_base), 32'd0);
        exp8_q.push_back({3'b000, 9'h05A});
        send_frame(1'b0, 8, 9'h05A, 1'b0, 1'b0, 1, 1'b1);
        wait_clks(40);
        check("post_rst_loads", 32'(loads8 - loads_base), 32'd1);
        check("post_rst_data", 32'(data8), 32'h5A);

        check("exp8_drained", 32'(exp8_q.size()), 32'd0);
        check("exp7_drained", 32'(exp7_q.size()), 32'd0);
        check("ovr7_none", 32'(ovr_cnt7), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1_800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
